// File: rtl/input_buffer_rd_sched_if.sv
// Handshake/bus bundle between the tile controller, the read scheduler and the
// three input-buffer SRAM read ports.
interface input_buffer_rd_sched_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] cfg_base_a;
   logic [ADDR_WIDTH-1:0] cfg_base_b;
   logic [ADDR_WIDTH-1:0] cfg_base_c;
   logic [LEN_WIDTH-1:0]  cfg_len_a;
   logic [LEN_WIDTH-1:0]  cfg_len_b;
   logic                  cfg_bias_en;
   logic                  a_ready;

   logic [ADDR_WIDTH-1:0] rd_addr_a;
   logic                  rd_en_a;
   logic [ADDR_WIDTH-1:0] rd_addr_b;
   logic                  rd_en_b;
   logic [ADDR_WIDTH-1:0] rd_addr_c;
   logic                  rd_en_c;
   logic                  a_valid;
   logic                  a_last;
   logic                  b_valid;
   logic                  b_last;
   logic                  c_valid;
   logic                  busy;
   logic                  done;

   modport master (
      output start, cfg_base_a, cfg_base_b, cfg_base_c, cfg_len_a, cfg_len_b,
             cfg_bias_en, a_ready,
      input  rd_addr_a, rd_en_a, rd_addr_b, rd_en_b, rd_addr_c, rd_en_c,
             a_valid, a_last, b_valid, b_last, c_valid, busy, done
   );

   modport slave (
      input  start, cfg_base_a, cfg_base_b, cfg_base_c, cfg_len_a, cfg_len_b,
             cfg_bias_en, a_ready,
      output rd_addr_a, rd_en_a, rd_addr_b, rd_en_b, rd_addr_c, rd_en_c,
             a_valid, a_last, b_valid, b_last, c_valid, busy, done
   );
endinterface

// File: rtl/input_buffer_rd_sched.sv
// Read-side sequencer for the input buffer: weight preload on port B, then
// back-pressured activation streaming on port A with optional bias reads on C.
module input_buffer_rd_sched #(
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input logic                    clk,
   input logic                    rst_n,
   input_buffer_rd_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_a_q, base_b_q, base_c_q;
   logic [LEN_WIDTH-1:0]  len_a_q, len_b_q;
   logic                  bias_en_q;
   logic [LEN_WIDTH-1:0]  idx_a_q, idx_a_d;
   logic [LEN_WIDTH-1:0]  idx_b_q, idx_b_d;
   logic                  a_valid_q, a_last_q, b_valid_q, b_last_q, c_valid_q;
   logic                  done_q;

   logic                  load_cfg;
   logic                  en_a, en_b, en_c;
   logic                  last_a, last_b;
   logic [ADDR_WIDTH-1:0] addr_a, addr_b, addr_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_a_d  = idx_a_q;
      idx_b_d  = idx_b_q;
      load_cfg = 1'b0;
      en_a     = 1'b0;
      en_b     = 1'b0;
      en_c     = 1'b0;
      last_a   = 1'b0;
      last_b   = 1'b0;
      addr_a   = '0;
      addr_b   = '0;
      addr_c   = '0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               load_cfg = 1'b1;
               idx_a_d  = '0;
               idx_b_d  = '0;
               if (bus.cfg_len_b != '0) begin
                  state_d = LOAD_W;
               end else if (bus.cfg_len_a != '0) begin
                  state_d = STREAM;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         LOAD_W: begin
            en_b    = 1'b1;
            addr_b  = base_b_q + idx_b_q[ADDR_WIDTH-1:0];
            last_b  = (idx_b_q == len_b_q - LEN_WIDTH'(1));
            idx_b_d = idx_b_q + LEN_WIDTH'(1);
            if (last_b) begin
               state_d = (len_a_q != '0) ? STREAM : DRAIN;
            end
         end
         STREAM: begin
            // Issue follows a_ready combinationally; addresses come only from registers.
            en_a   = bus.a_ready;
            en_c   = bus.a_ready & bias_en_q;
            addr_a = base_a_q + idx_a_q[ADDR_WIDTH-1:0];
            if (bias_en_q) begin
               addr_c = base_c_q + idx_a_q[ADDR_WIDTH-1:0];
            end
            last_a = en_a && (idx_a_q == len_a_q - LEN_WIDTH'(1));
            if (en_a) begin
               idx_a_d = idx_a_q + LEN_WIDTH'(1);
            end
            if (last_a) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_a_q  <= '0;
         base_b_q  <= '0;
         base_c_q  <= '0;
         len_a_q   <= '0;
         len_b_q   <= '0;
         bias_en_q <= 1'b0;
         idx_a_q   <= '0;
         idx_b_q   <= '0;
      end else begin
         if (load_cfg) begin
            base_a_q  <= bus.cfg_base_a;
            base_b_q  <= bus.cfg_base_b;
            base_c_q  <= bus.cfg_base_c;
            len_a_q   <= bus.cfg_len_a;
            len_b_q   <= bus.cfg_len_b;
            bias_en_q <= bus.cfg_bias_en;
         end
         idx_a_q <= idx_a_d;
         idx_b_q <= idx_b_d;
      end
   end

   // Valid strobes: one register stage to line up with the SRAM read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q <= 1'b0;
         a_last_q  <= 1'b0;
         b_valid_q <= 1'b0;
         b_last_q  <= 1'b0;
         c_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         a_valid_q <= en_a;
         a_last_q  <= last_a;
         b_valid_q <= en_b;
         b_last_q  <= last_b;
         c_valid_q <= en_c;
         done_q    <= (state_q == DRAIN);
      end
   end

   assign bus.rd_en_a   = en_a;
   assign bus.rd_addr_a = addr_a;
   assign bus.rd_en_b   = en_b;
   assign bus.rd_addr_b = addr_b;
   assign bus.rd_en_c   = en_c;
   assign bus.rd_addr_c = addr_c;
   assign bus.a_valid   = a_valid_q;
   assign bus.a_last    = a_last_q;
   assign bus.b_valid   = b_valid_q;
   assign bus.b_last    = b_last_q;
   assign bus.c_valid   = c_valid_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;

endmodule

// File: tb/tb_input_buffer_rd_sched.sv
// Directed bench for input_buffer_rd_sched: cycle-by-cycle expected flags and
// addresses for preload, streaming, back-pressure, wrap, restart and reset.
module tb_input_buffer_rd_sched;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   input_buffer_rd_sched_if #(.ADDR_WIDTH(10)) bus ();

   input_buffer_rd_sched #(.ADDR_WIDTH(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // flags = {rd_en_a, rd_en_b, rd_en_c, a_valid, a_last, b_valid, b_last, c_valid, busy, done}
   task automatic check_now(input string tag, input logic [9:0] f,
                            input logic [9:0] aa, input logic [9:0] ab, input logic [9:0] ac);
      chk({tag, "_flags"}, {22'd0, bus.rd_en_a, bus.rd_en_b, bus.rd_en_c, bus.a_valid,
                            bus.a_last, bus.b_valid, bus.b_last, bus.c_valid,
                            bus.busy, bus.done}, {22'd0, f});
      chk({tag, "_addr_a"}, {22'd0, bus.rd_addr_a}, {22'd0, aa});
      chk({tag, "_addr_b"}, {22'd0, bus.rd_addr_b}, {22'd0, ab});
      chk({tag, "_addr_c"}, {22'd0, bus.rd_addr_c}, {22'd0, ac});
   endtask

   task automatic cyc(input string tag, input logic [9:0] f,
                      input logic [9:0] aa, input logic [9:0] ab, input logic [9:0] ac);
      #1;
      check_now(tag, f, aa, ab, ac);
      @(posedge clk);
      #1;
   endtask

   task automatic run_basic(input string p);
      bus.cfg_base_b  = 10'h010;
      bus.cfg_len_b   = 11'd3;
      bus.cfg_base_a  = 10'h100;
      bus.cfg_len_a   = 11'd4;
      bus.cfg_base_c  = 10'h000;
      bus.cfg_bias_en = 1'b0;
      bus.a_ready     = 1'b1;
      bus.start       = 1'b1;
      cyc({p, "_c0"},  10'b0000000000, 10'h000, 10'h000, 10'h000);
      bus.start = 1'b0;
      cyc({p, "_c1"},  10'b0100000010, 10'h000, 10'h010, 10'h000);
      cyc({p, "_c2"},  10'b0100010010, 10'h000, 10'h011, 10'h000);
      cyc({p, "_c3"},  10'b0100010010, 10'h000, 10'h012, 10'h000);
      cyc({p, "_c4"},  10'b1000011010, 10'h100, 10'h000, 10'h000);
      cyc({p, "_c5"},  10'b1001000010, 10'h101, 10'h000, 10'h000);
      cyc({p, "_c6"},  10'b1001000010, 10'h102, 10'h000, 10'h000);
      cyc({p, "_c7"},  10'b1001000010, 10'h103, 10'h000, 10'h000);
      cyc({p, "_c8"},  10'b0001100010, 10'h000, 10'h000, 10'h000);
      cyc({p, "_c9"},  10'b0000000001, 10'h000, 10'h000, 10'h000);
      cyc({p, "_c10"}, 10'b0000000000, 10'h000, 10'h000, 10'h000);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n           = 1'b0;
      bus.start       = 1'b0;
      bus.cfg_base_a  = '0;
      bus.cfg_base_b  = '0;
      bus.cfg_base_c  = '0;
      bus.cfg_len_a   = '0;
      bus.cfg_len_b   = '0;
      bus.cfg_bias_en = 1'b0;
      bus.a_ready     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_now("reset", 10'b0000000000, 10'h000, 10'h000, 10'h000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_basic("basic");

      // Back-pressure on A, no preload.
      bus.cfg_len_b  = 11'd0;
      bus.cfg_len_a  = 11'd3;
      bus.cfg_base_a = 10'h200;
      bus.start      = 1'b1;
      bus.a_ready    = 1'b0;
      cyc("bp_c0", 10'b0000000000, 10'h000, 10'h000, 10'h000);
      bus.start   = 1'b0;
      bus.a_ready = 1'b1;
      cyc("bp_c1", 10'b1000000010, 10'h200, 10'h000, 10'h000);
      bus.a_ready = 1'b0;
      cyc("bp_c2", 10'b0001000010, 10'h201, 10'h000, 10'h000);
      cyc("bp_c3", 10'b0000000010, 10'h201, 10'h000, 10'h000);
      bus.a_ready = 1'b1;
      cyc("bp_c4", 10'b1000000010, 10'h201, 10'h000, 10'h000);
      cyc("bp_c5", 10'b1001000010, 10'h202, 10'h000, 10'h000);
      cyc("bp_c6", 10'b0001100010, 10'h000, 10'h000, 10'h000);
      cyc("bp_c7", 10'b0000000001, 10'h000, 10'h000, 10'h000);

      // Bias lockstep with address wrap on A and C.
      bus.cfg_base_a  = 10'h3FE;
      bus.cfg_base_c  = 10'h3FF;
      bus.cfg_len_a   = 11'd3;
      bus.cfg_bias_en = 1'b1;
      bus.start       = 1'b1;
      cyc("bias_c0", 10'b0000000000, 10'h000, 10'h000, 10'h000);
      bus.start       = 1'b0;
      bus.cfg_bias_en = 1'b0;
      cyc("bias_c1", 10'b1010000010, 10'h3FE, 10'h000, 10'h3FF);
      cyc("bias_c2", 10'b1011000110, 10'h3FF, 10'h000, 10'h000);
      cyc("bias_c3", 10'b1011000110, 10'h000, 10'h000, 10'h001);
      cyc("bias_c4", 10'b0001100110, 10'h000, 10'h000, 10'h000);
      cyc("bias_c5", 10'b0000000001, 10'h000, 10'h000, 10'h000);

      // Zero lengths, then restart on the done cycle with B wrap and mid-run changes.
      bus.cfg_len_a = 11'd0;
      bus.cfg_len_b = 11'd0;
      bus.start     = 1'b1;
      cyc("zero_c0", 10'b0000000000, 10'h000, 10'h000, 10'h000);
      bus.start = 1'b0;
      cyc("zero_c1", 10'b0000000010, 10'h000, 10'h000, 10'h000);
      bus.cfg_base_b = 10'h3FF;
      bus.cfg_len_b  = 11'd2;
      bus.cfg_base_a = 10'h050;
      bus.cfg_len_a  = 11'd1;
      bus.start      = 1'b1;
      cyc("zero_c2", 10'b0000000001, 10'h000, 10'h000, 10'h000);
      bus.start = 1'b0;
      cyc("rs_c3", 10'b0100000010, 10'h000, 10'h3FF, 10'h000);
      bus.cfg_base_b = 10'h123;
      bus.cfg_len_b  = 11'd5;
      bus.cfg_base_a = 10'h277;
      bus.cfg_len_a  = 11'd4;
      bus.start      = 1'b1;
      cyc("rs_c4", 10'b0100010010, 10'h000, 10'h000, 10'h000);
      bus.start = 1'b0;
      cyc("rs_c5", 10'b1000011010, 10'h050, 10'h000, 10'h000);
      cyc("rs_c6", 10'b0001100010, 10'h000, 10'h000, 10'h000);
      cyc("rs_c7", 10'b0000000001, 10'h000, 10'h000, 10'h000);
      cyc("rs_c8", 10'b0000000000, 10'h000, 10'h000, 10'h000);

      // Asynchronous reset in the middle of a stream.
      bus.cfg_len_b  = 11'd0;
      bus.cfg_len_a  = 11'd5;
      bus.cfg_base_a = 10'h040;
      bus.a_ready    = 1'b1;
      bus.start      = 1'b1;
      cyc("rst_c0", 10'b0000000000, 10'h000, 10'h000, 10'h000);
      bus.start = 1'b0;
      cyc("rst_c1", 10'b1000000010, 10'h040, 10'h000, 10'h000);
      cyc("rst_c2", 10'b1001000010, 10'h041, 10'h000, 10'h000);
      #1;
      check_now("rst_c3", 10'b1001000010, 10'h042, 10'h000, 10'h000);
      #2;
      rst_n = 1'b0;
      #1;
      check_now("rst_async", 10'b0000000000, 10'h000, 10'h000, 10'h000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("rst_post0", 10'b0000000000, 10'h000, 10'h000, 10'h000);
      cyc("rst_post1", 10'b0000000000, 10'h000, 10'h000, 10'h000);
      cyc("rst_post2", 10'b0000000000, 10'h000, 10'h000, 10'h000);

      run_basic("again");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
